// File: rtl/seg7_pkg.sv
// Seven-segment pattern constants shared by the display encoder and the
// scan receiver. Patterns are active-high, packed as {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam int SEG7_W = 7;

  // Bit position of each segment inside a 7-bit pattern.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [SEG7_W-1:0] SEG7_HEX_0 = 7'h7E;
  localparam logic [SEG7_W-1:0] SEG7_HEX_1 = 7'h30;
  localparam logic [SEG7_W-1:0] SEG7_HEX_2 = 7'h6D;
  localparam logic [SEG7_W-1:0] SEG7_HEX_3 = 7'h79;
  localparam logic [SEG7_W-1:0] SEG7_HEX_4 = 7'h33;
  localparam logic [SEG7_W-1:0] SEG7_HEX_5 = 7'h5B;
  localparam logic [SEG7_W-1:0] SEG7_HEX_6 = 7'h5F;
  localparam logic [SEG7_W-1:0] SEG7_HEX_7 = 7'h70;
  localparam logic [SEG7_W-1:0] SEG7_HEX_8 = 7'h7F;
  localparam logic [SEG7_W-1:0] SEG7_HEX_9 = 7'h7B;
  localparam logic [SEG7_W-1:0] SEG7_HEX_A = 7'h77;
  localparam logic [SEG7_W-1:0] SEG7_HEX_B = 7'h1F;
  localparam logic [SEG7_W-1:0] SEG7_HEX_C = 7'h4E;
  localparam logic [SEG7_W-1:0] SEG7_HEX_D = 7'h3D;
  localparam logic [SEG7_W-1:0] SEG7_HEX_E = 7'h4F;
  localparam logic [SEG7_W-1:0] SEG7_HEX_F = 7'h47;
  localparam logic [SEG7_W-1:0] SEG7_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder: pattern -> {nibble, is_hex, is_blank}.
// A pattern that is neither a hex glyph nor blank reports is_hex=0, is_blank=0.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG7_W-1:0] i_pattern,
  output logic [3:0]        o_nibble,
  output logic              o_is_hex,
  output logic              o_is_blank
);

  // Table lookup of the sixteen glyphs plus the blank pattern.
  always_comb begin
    o_nibble   = 4'h0;
    o_is_hex   = 1'b1;
    o_is_blank = 1'b0;
    case (i_pattern)
      SEG7_HEX_0: o_nibble = 4'h0;
      SEG7_HEX_1: o_nibble = 4'h1;
      SEG7_HEX_2: o_nibble = 4'h2;
      SEG7_HEX_3: o_nibble = 4'h3;
      SEG7_HEX_4: o_nibble = 4'h4;
      SEG7_HEX_5: o_nibble = 4'h5;
      SEG7_HEX_6: o_nibble = 4'h6;
      SEG7_HEX_7: o_nibble = 4'h7;
      SEG7_HEX_8: o_nibble = 4'h8;
      SEG7_HEX_9: o_nibble = 4'h9;
      SEG7_HEX_A: o_nibble = 4'hA;
      SEG7_HEX_B: o_nibble = 4'hB;
      SEG7_HEX_C: o_nibble = 4'hC;
      SEG7_HEX_D: o_nibble = 4'hD;
      SEG7_HEX_E: o_nibble = 4'hE;
      SEG7_HEX_F: o_nibble = 4'hF;
      SEG7_BLANK: begin
        o_is_hex   = 1'b0;
        o_is_blank = 1'b1;
      end
      default: o_is_hex = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Multiplexed seven-segment receiver: synchronises segment/select lines,
// waits for STABLE_CYCLES identical one-hot samples, then decodes the pattern
// into the selected digit's register. No handshake: upd_pulse is a
// one-cycle strobe with upd_idx naming the digit written that cycle; there
// is no ready/backpressure.
// Optional build macro SEG7_SCAN_RX_DP_EN adds dp_in / digit_dp.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int STABLE_CYCLES  = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [SEG7_W-1:0]       seg_in,
  input  logic [NUM_DIGITS-1:0]   sel_in,
`ifdef SEG7_SCAN_RX_DP_EN
  input  logic                    dp_in,
  output logic [NUM_DIGITS-1:0]   digit_dp,
`endif
  output logic [4*NUM_DIGITS-1:0] digit_value,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_error,
  output logic                    upd_pulse,
  output logic [2:0]              upd_idx
);

`ifdef SEG7_SCAN_RX_DP_EN
  localparam int SMPL_W = SEG7_W + NUM_DIGITS + 1;
`else
  localparam int SMPL_W = SEG7_W + NUM_DIGITS;
`endif
  localparam int                 CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  logic [SMPL_W-1:0]       w_raw;
  logic [SMPL_W-1:0]       r_sync1;
  logic [SMPL_W-1:0]       r_sync2;
  logic [SMPL_W-1:0]       r_prev;
  logic [SMPL_W-1:0]       w_s;
  logic [SEG7_W-1:0]       w_seg;
  logic [NUM_DIGITS-1:0]   w_sel;
  logic                    w_same;
  logic                    w_onehot;
  logic                    w_capture;
  logic [2:0]              w_idx;
  logic [CNT_W-1:0]        r_cnt;
  logic [3:0]              w_nibble;
  logic                    w_is_hex;
  logic                    w_is_blank;
  logic [4*NUM_DIGITS-1:0] r_digit_value;
  logic [NUM_DIGITS-1:0]   r_digit_valid;
  logic [NUM_DIGITS-1:0]   r_digit_error;
  logic                    r_upd_pulse;
  logic [2:0]              r_upd_idx;
`ifdef SEG7_SCAN_RX_DP_EN
  logic [NUM_DIGITS-1:0]   r_digit_dp;

  assign w_raw    = {dp_in, sel_in, seg_in};
  assign digit_dp = r_digit_dp;
`else
  assign w_raw    = {sel_in, seg_in};
`endif

  // Polarity is normalised after the synchroniser; comparing raw samples
  // is equivalent because the inversion is a bijection.
  assign w_s       = SEG_ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_seg     = w_s[SEG7_W-1:0];
  assign w_sel     = w_s[SEG7_W +: NUM_DIGITS];
  assign w_same    = (r_sync2 == r_prev);
  assign w_onehot  = (w_sel != '0) && ((w_sel & (w_sel - NUM_DIGITS'(1))) == '0);
  assign w_capture = w_same && w_onehot && (r_cnt == CNT_CAP);

  // Index of the active select bit (only meaningful when w_onehot).
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_sel[i]) w_idx = 3'(i);
    end
  end

  seg7_decode u_decode (
    .i_pattern  (w_seg),
    .o_nibble   (w_nibble),
    .o_is_hex   (w_is_hex),
    .o_is_blank (w_is_blank)
  );

  // Two-flop synchroniser plus one-sample history for change detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Stability counter: restarts on any change or non-one-hot select, saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_same || !w_onehot) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Capture the decoded pattern into the selected digit once per stable run.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_digit_value <= '0;
      r_digit_valid <= '0;
      r_digit_error <= '0;
      r_upd_pulse   <= 1'b0;
      r_upd_idx     <= 3'd0;
`ifdef SEG7_SCAN_RX_DP_EN
      r_digit_dp    <= '0;
`endif
    end else begin
      r_upd_pulse <= w_capture;
      if (w_capture) r_upd_idx <= w_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (w_capture && w_sel[i]) begin
          if (w_is_hex) begin
            r_digit_value[4*i +: 4] <= w_nibble;
            r_digit_valid[i]        <= 1'b1;
            r_digit_error[i]        <= 1'b0;
          end else begin
            r_digit_valid[i]        <= 1'b0;
            r_digit_error[i]        <= !w_is_blank;
          end
`ifdef SEG7_SCAN_RX_DP_EN
          r_digit_dp[i] <= w_s[SMPL_W-1];
`endif
        end
      end
    end
  end

  assign digit_value = r_digit_value;
  assign digit_valid = r_digit_valid;
  assign digit_error = r_digit_error;
  assign upd_pulse   = r_upd_pulse;
  assign upd_idx     = r_upd_idx;

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Testbench for seg7_scan_rx: NUM_DIGITS=2, STABLE_CYCLES=4, active-high inputs.
// A negedge monitor pops expected capture words whenever upd_pulse is seen.
module tb_seg7_scan_rx;

  localparam int ND = 2;
  localparam int SC = 4;
`ifdef SEG7_SCAN_RX_DP_EN
  localparam int EXP_W = 3 + 4*ND + ND + ND + ND;
`else
  localparam int EXP_W = 3 + 4*ND + ND + ND;
`endif

  // ---------------- clock / reset ----------------
  logic          clock  = 1'b0;
  logic          reset  = 1'b1;
  logic [6:0]    seg_in = 7'h00;
  logic [ND-1:0] sel_in = '0;
  logic          dp_in  = 1'b0;
  logic [4*ND-1:0] digit_value;
  logic [ND-1:0]   digit_valid;
  logic [ND-1:0]   digit_error;
  logic            upd_pulse;
  logic [2:0]      upd_idx;
`ifdef SEG7_SCAN_RX_DP_EN
  logic [ND-1:0]   digit_dp;
`endif

  always #5 clock = ~clock;

  seg7_scan_rx #(
    .NUM_DIGITS     (ND),
    .STABLE_CYCLES  (SC),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_in      (seg_in),
    .sel_in      (sel_in),
`ifdef SEG7_SCAN_RX_DP_EN
    .dp_in       (dp_in),
    .digit_dp    (digit_dp),
`endif
    .digit_value (digit_value),
    .digit_valid (digit_valid),
    .digit_error (digit_error),
    .upd_pulse   (upd_pulse),
    .upd_idx     (upd_idx)
  );

  // ---------------- scoreboard / model ----------------
  logic [EXP_W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  int pulse_cnt   = 0;

  logic [6:0] hex_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  logic [3:0]    m_val [ND];
  logic [ND-1:0] m_valid;
  logic [ND-1:0] m_err;
  logic [ND-1:0] m_dp;
  logic [2:0]    m_idx;

  function automatic logic [EXP_W-1:0] model_word();
`ifdef SEG7_SCAN_RX_DP_EN
    return {m_idx, m_val[1], m_val[0], m_valid, m_err, m_dp};
`else
    return {m_idx, m_val[1], m_val[0], m_valid, m_err};
`endif
  endfunction

  function automatic logic [EXP_W-1:0] dut_word();
`ifdef SEG7_SCAN_RX_DP_EN
    return {upd_idx, digit_value, digit_valid, digit_error, digit_dp};
`else
    return {upd_idx, digit_value, digit_valid, digit_error};
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_val[i] = 4'h0;
    m_valid = '0;
    m_err   = '0;
    m_dp    = '0;
    m_idx   = 3'd0;
  endtask

  // Update the model for one expected capture and queue the resulting outputs.
  task automatic push_capture(input int idx, input logic [6:0] seg, input logic dp);
    int hit;
    hit = -1;
    for (int k = 0; k < 16; k++) if (hex_tab[k] == seg) hit = k;
    if (hit >= 0) begin
      m_val[idx]   = 4'(hit);
      m_valid[idx] = 1'b1;
      m_err[idx]   = 1'b0;
    end else if (seg == 7'h00) begin
      m_valid[idx] = 1'b0;
      m_err[idx]   = 1'b0;
    end else begin
      m_valid[idx] = 1'b0;
      m_err[idx]   = 1'b1;
    end
    m_dp[idx] = dp;
    m_idx     = 3'(idx);
    exp_q.push_back(model_word());
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clock) begin
    if (upd_pulse === 1'b1) begin
      logic [EXP_W-1:0] exp_w;
      pulse_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got word %h with no capture expected", dut_word());
      end else begin
        exp_w = exp_q.pop_front();
        if (dut_word() !== exp_w) begin
          miscompares++;
          $display("FAIL capture_word: got %h expected %h", dut_word(), exp_w);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [ND-1:0] sel, input logic [6:0] seg, input logic dp);
    @(posedge clock);
    #1;
    sel_in = sel;
    seg_in = seg;
    dp_in  = dp;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int start;
    reset = 1'b1;
    idle(3);
    @(negedge clock);
    vectors++;
    if ({digit_value, digit_valid, digit_error, upd_pulse, upd_idx} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0",
               {digit_value, digit_valid, digit_error, upd_pulse, upd_idx});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    start = pulse_cnt;
    idle(100);
    @(negedge clock);
    vectors++;
    if ({digit_value, digit_valid, digit_error, upd_idx} !== '0) begin
      miscompares++;
      $display("FAIL idle_outputs: got %h expected 0",
               {digit_value, digit_valid, digit_error, upd_idx});
    end
    vectors++;
    if (pulse_cnt !== start) begin
      miscompares++;
      $display("FAIL idle_pulses: got %0d expected %0d", pulse_cnt, start);
    end
  endtask

  task automatic test_latency();
    int start;
    start = pulse_cnt;
    push_capture(0, 7'h6D, 1'b0);
    drive(2'b01, 7'h6D, 1'b0);
    for (int k = 0; k <= SC + 2; k++) begin
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (upd_pulse !== (k == SC + 2)) begin
        miscompares++;
        $display("FAIL latency_edge%0d: got upd_pulse %b expected %b", k, upd_pulse, k == SC + 2);
      end
    end
    idle(50);
    @(negedge clock);
    vectors++;
    if (pulse_cnt !== start + 1) begin
      miscompares++;
      $display("FAIL hold_single_pulse: got %0d pulses expected 1", pulse_cnt - start);
    end
  endtask

  task automatic test_alternate_glitch();
    logic [ND-1:0] w_sel [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [6:0]    w_seg [4] = '{7'h30, 7'h47, 7'h30, 7'h47};
    int start;
    start = pulse_cnt;
    for (int w = 0; w < 4; w++) begin
      push_capture(w_sel[w] == 2'b01 ? 0 : 1, w_seg[w], 1'b0);
      drive(w_sel[w], w_seg[w], 1'b0);
      if (w == 2) begin
        idle(2);
        drive(w_sel[w], 7'h7F, 1'b0);
        drive(w_sel[w], w_seg[w], 1'b0);
        idle(14);
      end else begin
        idle(10);
      end
    end
    @(negedge clock);
    vectors++;
    if (pulse_cnt !== start + 4) begin
      miscompares++;
      $display("FAIL alternate_pulses: got %0d expected 4", pulse_cnt - start);
    end
    vectors++;
    if ({digit_value, digit_valid} !== {8'hF1, 2'b11}) begin
      miscompares++;
      $display("FAIL alternate_value: got %h/%b expected f1/11", digit_value, digit_valid);
    end
  endtask

  task automatic test_error_blank();
    push_capture(1, 7'h01, 1'b0);
    drive(2'b10, 7'h01, 1'b0);
    idle(12);
    @(negedge clock);
    vectors++;
    if ({digit_error, digit_valid, digit_value} !== {2'b10, 2'b01, 8'hF1}) begin
      miscompares++;
      $display("FAIL invalid_pattern: got err %b valid %b value %h expected 10/01/f1",
               digit_error, digit_valid, digit_value);
    end
    push_capture(1, 7'h00, 1'b0);
    drive(2'b10, 7'h00, 1'b0);
    idle(12);
    @(negedge clock);
    vectors++;
    if ({digit_error, digit_valid, digit_value} !== {2'b00, 2'b01, 8'hF1}) begin
      miscompares++;
      $display("FAIL blank_pattern: got err %b valid %b value %h expected 00/01/f1",
               digit_error, digit_valid, digit_value);
    end
  endtask

  task automatic test_multi_select();
    int start;
    start = pulse_cnt;
    drive(2'b11, 7'h7E, 1'b0);
    idle(100);
    @(negedge clock);
    vectors++;
    if (pulse_cnt !== start) begin
      miscompares++;
      $display("FAIL multi_sel_pulses: got %0d expected 0", pulse_cnt - start);
    end
    vectors++;
    if ({digit_value, digit_valid, digit_error} !== {m_val[1], m_val[0], m_valid, m_err}) begin
      miscompares++;
      $display("FAIL multi_sel_outputs: got %h expected %h",
               {digit_value, digit_valid, digit_error}, {m_val[1], m_val[0], m_valid, m_err});
    end
    idle(2);
    drive(2'b00, 7'h7E, 1'b0);
    idle(10);
  endtask

  task automatic test_reset_mid_count();
    int start;
    start = pulse_cnt;
    drive(2'b01, 7'h7E, 1'b0);
    for (int k = 0; k <= SC + 1; k++) begin
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (upd_pulse !== 1'b0) begin
        miscompares++;
        $display("FAIL pre_reset_edge%0d: got upd_pulse %b expected 0", k, upd_pulse);
      end
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({upd_pulse, digit_value, digit_valid, digit_error} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_outputs: got %h expected 0",
               {upd_pulse, digit_value, digit_valid, digit_error});
    end
    reset = 1'b0;
    model_reset();
    push_capture(0, 7'h7E, 1'b0);
    for (int k = 0; k <= SC + 2; k++) begin
      @(posedge clock);
      @(negedge clock);
      vectors++;
      if (upd_pulse !== (k == SC + 2)) begin
        miscompares++;
        $display("FAIL post_reset_edge%0d: got upd_pulse %b expected %b", k, upd_pulse, k == SC + 2);
      end
    end
    idle(4);
    @(negedge clock);
    vectors++;
    if (pulse_cnt !== start + 1) begin
      miscompares++;
      $display("FAIL reset_abort_pulses: got %0d expected 1", pulse_cnt - start);
    end
  endtask

`ifdef SEG7_SCAN_RX_DP_EN
  task automatic test_dp();
    push_capture(1, 7'h7E, 1'b1);
    drive(2'b10, 7'h7E, 1'b1);
    idle(12);
    @(negedge clock);
    vectors++;
    if ({digit_dp, digit_value[7:4], digit_valid[1]} !== {2'b10, 4'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL dp_capture: got dp %b value %h valid %b expected 10/0/1",
               digit_dp, digit_value[7:4], digit_valid[1]);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_alternate_glitch();
    test_error_blank();
    test_multi_select();
    test_reset_mid_count();
`ifdef SEG7_SCAN_RX_DP_EN
    test_dp();
`endif
    idle(5);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL pending_captures: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
